imem_fetch_arbiter: RTL and testbench

- Sole master of the combinational 6-bit instruction ROM (8-bit address).
- Sequences instruction fetch for the MCPU core through a one-entry registered output buffer with a valid/ready handshake.
- Handles branch redirects and halts on end-of-program.
- Shares the ROM read port with a debug readout requester, using a bounded-starvation arbiter.

---
 rtl/imem_fetch_arbiter.sv | 129 ++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// Instruction fetch sequencer and sole owner of the instruction ROM read port.
// Fetched words go to the core through a one-entry valid/ready buffer. Debug reads
// share the ROM port. A saturating wait counter bounds how long debug can starve.
module imem_fetch_arbiter #(
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          INSTR_W     = 6,
  parameter logic [INSTR_W-1:0]   HALT_OPCODE = INSTR_W'(6'h3F),
  parameter int unsigned          DBG_MAXWAIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               cpu_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  input  logic               dbg_req,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic               dbg_ack,
  output logic [INSTR_W-1:0] dbg_data
);

  localparam int unsigned WAIT_W = (DBG_MAXWAIT < 1) ? 1 : $clog2(DBG_MAXWAIT + 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               halted_q, halted_d;
  logic               dbg_ack_q, dbg_ack_d;
  logic [INSTR_W-1:0] dbg_data_q, dbg_data_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic fetch_want;
  logic dbg_elig;
  logic wait_full;
  logic dbg_gnt;
  logic fetch_gnt;

  // Grant decision: debug wins when fetch is idle or debug has waited long enough.
  always_comb begin
    fetch_want = ~halted_q & ~redirect & (~instr_valid_q | cpu_ready);
    dbg_elig   = dbg_req & ~dbg_ack_q;
    wait_full  = (wait_q == WAIT_W'(DBG_MAXWAIT));
    dbg_gnt    = dbg_elig & (~fetch_want | wait_full);
    fetch_gnt  = fetch_want & ~dbg_gnt;
    if (!rst_n) begin
      imem_addr = '0;
    end else if (dbg_gnt) begin
      imem_addr = dbg_addr;
    end else begin
      imem_addr = pc_q;
    end
  end

  // Next-state for the fetch buffer, halt flag, debug return path and wait counter.
  always_comb begin
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    halted_d      = halted_q;
    dbg_ack_d     = dbg_gnt;
    dbg_data_d    = dbg_data_q;
    wait_d        = wait_q;

    if (redirect) begin
      // Flush the buffer; the target is fetched on the following cycle.
      pc_d          = redirect_pc;
      instr_valid_d = 1'b0;
      halted_d      = 1'b0;
    end else if (fetch_gnt) begin
      instr_d       = imem_data;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + ADDR_W'(1);
      if (imem_data == HALT_OPCODE) begin
        halted_d = 1'b1;
      end
    end else if (instr_valid_q && cpu_ready) begin
      instr_valid_d = 1'b0;
    end

    if (dbg_gnt) begin
      dbg_data_d = imem_data;
    end

    if (dbg_gnt || !dbg_req) begin
      wait_d = '0;
    end else if (dbg_elig && !wait_full) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      halted_q      <= 1'b0;
      dbg_ack_q     <= 1'b0;
      dbg_data_q    <= '0;
      wait_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      halted_q      <= halted_d;
      dbg_ack_q     <= dbg_ack_d;
      dbg_data_q    <= dbg_data_d;
      wait_q        <= wait_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;
  assign dbg_ack     = dbg_ack_q;
  assign dbg_data    = dbg_data_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: directed scenarios plus a randomized run checked
// against a stream-level model (expected pc sequence, halt stop, debug latency bound).
module tb_imem_fetch_arbiter;

  localparam logic [5:0] HALT = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [5:0] imem_data;
  logic       instr_valid;
  logic [5:0] instr;
  logic [7:0] instr_pc;
  logic       cpu_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halted;
  logic       dbg_req;
  logic [7:0] dbg_addr;
  logic       dbg_ack;
  logic [5:0] dbg_data;

  logic [5:0] rom [256];
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  imem_fetch_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .cpu_ready   (cpu_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_ack     (dbg_ack),
    .dbg_data    (dbg_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom();
    for (int a = 0; a < 256; a++) begin
      rom[a] = (a < 8'h40) ? 6'($urandom_range(0, 62)) : HALT;
    end
    rom[8'h00] = 6'h1F; rom[8'h01] = 6'h2F; rom[8'h02] = 6'h12;
    rom[8'h05] = 6'h12; rom[8'h06] = 6'h29; rom[8'h0A] = 6'h30;
    rom[8'h11] = 6'h15; rom[8'h1B] = 6'h1A; rom[8'h20] = 6'h15;
    rom[8'h21] = 6'h10; rom[8'h22] = 6'h3A; rom[8'h23] = HALT;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    dbg_req = 1'b1; dbg_addr = 8'h55;
    tick(); tick();
    vectors++;
    if ({instr_valid, instr, instr_pc, halted, dbg_ack, dbg_data, imem_addr} !== 31'd0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b i=%h pc=%h h=%b ack=%b dd=%h addr=%h, all zero required",
               instr_valid, instr, instr_pc, halted, dbg_ack, dbg_data, imem_addr);
    end
    dbg_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [5:0] ei [3];
    ei[0] = 6'h1F; ei[1] = 6'h2F; ei[2] = 6'h12;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, ei[k], 8'(k)}) begin
        miscompares++;
        $display("FAIL stream_%0d: got v=%b i=%h pc=%h, need v=1 i=%h pc=%h",
                 k, instr_valid, instr, instr_pc, ei[k], 8'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    while (instr_pc !== 8'h05 && n < 10) begin
      tick(); n++;
    end
    vectors++;
    if (instr_pc !== 8'h05) begin
      miscompares++;
      $display("FAIL bp_reach: got pc=%h, need 05", instr_pc);
    end
    cpu_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (imem_addr !== 8'h06) begin
        miscompares++;
        $display("FAIL bp_addr_%0d: got %h, need 06", k, imem_addr);
      end
      tick();
      vectors++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 6'h12, 8'h05}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got v=%b i=%h pc=%h, need 1/12/05", k, instr_valid, instr, instr_pc);
      end
    end
    cpu_ready = 1'b1;
    tick();
    vectors++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 6'h29, 8'h06}) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b i=%h pc=%h, need 1/29/06", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 8'h11;
    tick();
    redirect = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_flush: got v=%b, need 0", instr_valid);
    end
    tick();
    vectors++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 6'h15, 8'h11}) begin
      miscompares++;
      $display("FAIL redir_target: got v=%b i=%h pc=%h, need 1/15/11", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_halt();
    logic [5:0] ei [4];
    ei[0] = 6'h15; ei[1] = 6'h10; ei[2] = 6'h3A; ei[3] = HALT;
    redirect = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({instr_valid, instr, instr_pc, halted} !== {1'b1, ei[k], 8'(8'h20 + k), k == 3}) begin
        miscompares++;
        $display("FAIL halt_seq_%0d: got v=%b i=%h pc=%h h=%b", k, instr_valid, instr, instr_pc, halted);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({instr_valid, halted} !== 2'b01) begin
        miscompares++;
        $display("FAIL halt_drain_%0d: got v=%b h=%b, need v=0 h=1", k, instr_valid, halted);
      end
    end
  endtask

  task automatic test_debug_halted();
    logic [7:0] da [2];
    logic [5:0] dd [2];
    da[0] = 8'h0A; dd[0] = 6'h30; da[1] = 8'h40; dd[1] = HALT;
    for (int k = 0; k < 2; k++) begin
      dbg_req = 1'b1; dbg_addr = da[k];
      #1;
      vectors++;
      if (imem_addr !== da[k]) begin
        miscompares++;
        $display("FAIL dbgh_addr_%0d: got %h, need %h", k, imem_addr, da[k]);
      end
      tick();
      vectors++;
      if ({dbg_ack, dbg_data, instr_valid} !== {1'b1, dd[k], 1'b0}) begin
        miscompares++;
        $display("FAIL dbgh_ack_%0d: got ack=%b d=%h v=%b, need 1/%h/0", k, dbg_ack, dbg_data, instr_valid, dd[k]);
      end
      dbg_req = 1'b0;
      tick();
      vectors++;
      if ({dbg_ack, dbg_data} !== {1'b0, dd[k]}) begin
        miscompares++;
        $display("FAIL dbgh_hold_%0d: got ack=%b d=%h, need 0/%h", k, dbg_ack, dbg_data, dd[k]);
      end
    end
    redirect = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect = 1'b0;
    vectors++;
    if ({halted, instr_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL unhalt: got h=%b v=%b, need 0/0", halted, instr_valid);
    end
    tick();
    vectors++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 6'h1F, 8'h00}) begin
      miscompares++;
      $display("FAIL unhalt_fetch: got v=%b i=%h pc=%h, need 1/1F/00", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_starvation();
    dbg_req = 1'b1; dbg_addr = 8'h1B;
    for (int c = 1; c <= 4; c++) begin
      #1;
      vectors++;
      if (imem_addr !== ((c < 4) ? 8'(c) : 8'h1B)) begin
        miscompares++;
        $display("FAIL starve_addr_%0d: got %h", c, imem_addr);
      end
      tick();
      vectors++;
      if (c < 4) begin
        if ({instr_valid, instr_pc, dbg_ack} !== {1'b1, 8'(c), 1'b0}) begin
          miscompares++;
          $display("FAIL starve_fetch_%0d: got v=%b pc=%h ack=%b", c, instr_valid, instr_pc, dbg_ack);
        end
      end else if ({instr_valid, dbg_ack, dbg_data} !== {1'b0, 1'b1, 6'h1A}) begin
        miscompares++;
        $display("FAIL starve_grant: got v=%b ack=%b d=%h, need 0/1/1A", instr_valid, dbg_ack, dbg_data);
      end
    end
    dbg_req = 1'b0;
    tick();
    vectors++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, rom[4], 8'h04}) begin
      miscompares++;
      $display("FAIL starve_resume: got v=%b i=%h pc=%h, need 1/%h/04", instr_valid, instr, instr_pc, rom[4]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    dbg_req = 1'b1; dbg_addr = 8'h05;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({instr_valid, instr, instr_pc, halted, dbg_ack, dbg_data, imem_addr} !== 31'd0) begin
      miscompares++;
      $display("FAIL midreset_state: got v=%b pc=%h ack=%b dd=%h addr=%h", instr_valid, instr_pc, dbg_ack, dbg_data, imem_addr);
    end
    #2 rst_n = 1'b1;
    while (dbg_ack !== 1'b1 && n < 10) begin
      tick(); n++;
    end
    vectors++;
    if (n !== 4 || dbg_data !== rom[5]) begin
      miscompares++;
      $display("FAIL midreset_dbg: got ack after %0d edges data=%h, need 4 edges data=%h", n, dbg_data, rom[5]);
    end
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp_pc = 8'h00;
    bit         halt_seen = 1'b0;
    bit         dbg_active = 1'b0;
    logic [7:0] dbg_a = 8'h00;
    int         dbg_start = 0;
    int         transfers = 0;
    rst_n = 1'b0; cpu_ready = 1'b0; redirect = 1'b0; dbg_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (dbg_ack) begin
        vectors++;
        if (!dbg_active || dbg_data !== rom[dbg_a] || cyc - dbg_start > 4) begin
          miscompares++;
          $display("FAIL rnd_dbg cyc %0d: got active=%b d=%h lat=%0d, need d=%h lat<=4",
                   cyc, dbg_active, dbg_data, cyc - dbg_start, rom[dbg_a]);
        end
        dbg_active = 1'b0;
      end else if (dbg_active && cyc - dbg_start >= 4) begin
        vectors++; miscompares++;
        $display("FAIL rnd_dbg_timeout cyc %0d: no ack for addr %h", cyc, dbg_a);
        dbg_active = 1'b0;
      end
      if (!dbg_active && !dbg_ack && ($urandom % 5 == 0)) begin
        dbg_active = 1'b1; dbg_start = cyc; dbg_a = 8'($urandom);
        dbg_addr = dbg_a;
      end
      dbg_req     = dbg_active;
      cpu_ready   = ($urandom % 4) != 0;
      redirect    = ($urandom % 20 == 0) || (halt_seen && ($urandom % 4 == 0));
      redirect_pc = 8'($urandom_range(0, 8'h45));
      #1;
      if (redirect) begin
        exp_pc = redirect_pc; halt_seen = 1'b0;
      end else if (instr_valid && cpu_ready) begin
        vectors++;
        if (halt_seen || instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          miscompares++;
          $display("FAIL rnd_xfer cyc %0d: got i=%h pc=%h, need i=%h pc=%h (after_halt=%b)",
                   cyc, instr, instr_pc, rom[exp_pc], exp_pc, halt_seen);
        end
        halt_seen = (rom[exp_pc] == HALT);
        exp_pc    = exp_pc + 8'd1;
        transfers++;
      end
      tick();
    end
    vectors++;
    if (transfers < 100) begin
      miscompares++;
      $display("FAIL rnd_progress: got %0d transfers, need at least 100", transfers);
    end
    dbg_req = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    load_rom();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_debug_halted();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
